// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Each accepted op is registered, evaluated for one cycle, then held as a response until consumed.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] OP_MAX = 4'd10;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last;
  logic             r_id;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  logic w_idle;
  logic w_grant;
  logic w_rdy0;
  logic w_rdy1;
  logic w_acc;
  logic w_err;

  // Tie goes to the requester not granted last; r_last resets to 1 so requester 0 wins first.
  assign w_idle  = (r_state == S_IDLE) && !reset;
  assign w_grant = (req0_valid && req1_valid) ? !r_last : req1_valid;
  assign w_rdy0  = w_idle && req0_valid && !w_grant;
  assign w_rdy1  = w_idle && req1_valid && w_grant;
  assign w_acc   = w_rdy0 || w_rdy1;
  assign w_err   = (r_op > OP_MAX);

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign alu_ctrl   = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot of the winning request; later operand changes cannot reach the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_acc) begin
      r_last <= w_grant;
      r_id   <= w_grant;
      r_op   <= w_grant ? req1_op : req0_op;
      r_a    <= w_grant ? req1_a  : req0_a;
      r_b    <= w_grant ? req1_b  : req0_b;
    end
  end

  // Result capture; illegal codes report an error with a zeroed payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_id   <= r_id;
      r_rsp_err  <= w_err;
      r_rsp_data <= w_err ? '0 : alu_y;
      r_rsp_zero <= !w_err && alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a cycle-count based reference model.
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle counter, busy flag, when the response shows up, last grant.
  int           cyc;
  bit           busy;
  int           resp_at;
  int           last;
  logic         exp_id;
  logic [3:0]   exp_op;
  logic [W-1:0] exp_a, exp_b, exp_data;
  logic         exp_zero, exp_err;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      4'd6:    return a - b;
      4'd7:    return W'($signed(a) < $signed(b));
      4'd8:    return W'($signed(a) >>> b[4:0]);
      4'd9:    return ~(a | b);
      4'd10:   return W'(a < b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Shared ALU environment seen by the DUT.
  always_comb begin
    alu_y    = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero = (alu_y == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input logic v0, input logic [3:0] op0, input logic [W-1:0] a0,
                      input logic [W-1:0] b0, input logic v1, input logic [3:0] op1,
                      input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic rr, input logic rst);
    int  g;
    bit  e_r0, e_r1, e_rv;
    @(negedge clk);
    reset = rst; rsp_ready = rr;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    g    = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
    e_r0 = !rst && !busy && v0 && (g == 0);
    e_r1 = !rst && !busy && v1 && (g == 1);
    e_rv = busy && (cyc >= resp_at);
    chk("req0_ready", W'(req0_ready), W'(e_r0));
    chk("req1_ready", W'(req1_ready), W'(e_r1));
    chk("rsp_valid", W'(rsp_valid), W'(e_rv));
    if (e_rv) begin
      chk("rsp_id", W'(rsp_id), W'(exp_id));
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_zero", W'(rsp_zero), W'(exp_zero));
      chk("rsp_err", W'(rsp_err), W'(exp_err));
    end
    if (busy) begin
      chk("alu_ctrl", W'(alu_ctrl), W'(exp_op));
      chk("alu_a", alu_a, exp_a);
      chk("alu_b", alu_b, exp_b);
    end
    if (rst) begin
      busy = 1'b0;
      last = 1;
    end else if (e_rv && rr) begin
      busy = 1'b0;
    end else if (e_r0 || e_r1) begin
      busy     = 1'b1;
      resp_at  = cyc + 2;
      last     = g;
      exp_id   = (g == 1);
      exp_op   = e_r1 ? op1 : op0;
      exp_a    = e_r1 ? a1 : a0;
      exp_b    = e_r1 ? b1 : b0;
      exp_err  = (exp_op > 4'd10);
      exp_data = exp_err ? '0 : alu_fn(exp_op, exp_a, exp_b);
      exp_zero = !exp_err && (exp_data == '0);
    end
    cyc++;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0, rr, 1'b0);
  endtask

  initial begin
    logic [3:0]   r_op0, r_op1;
    logic [W-1:0] r_a0, r_b0, r_a1, r_b1;
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    cyc = 0; busy = 1'b0; resp_at = 0; last = 1;
    exp_id = 1'b0; exp_op = '0; exp_a = '0; exp_b = '0;
    exp_data = '0; exp_zero = 1'b0; exp_err = 1'b0;

    // Reset state
    idle(1'b1);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_id", W'(rsp_id), '0);
    chk("rst_rsp_zero", W'(rsp_zero), '0);
    chk("rst_rsp_err", W'(rsp_err), '0);
    chk("rst_alu_ctrl", W'(alu_ctrl), '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);

    // Single add from requester 0, response two cycles after accept
    step(1'b1, 4'b0010, 32'd5, 32'd7, 1'b0, 4'd0, '0, '0, 1'b1, 1'b0);
    idle(1'b1);
    chk("add_early_valid", W'(rsp_valid), '0);
    idle(1'b1);
    chk("add_valid", W'(rsp_valid), 32'd1);
    chk("add_data", rsp_data, 32'd12);
    chk("add_id", W'(rsp_id), '0);
    chk("add_zero", W'(rsp_zero), '0);

    // Both held valid from reset: grants alternate starting with requester 0
    step(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      repeat (3) step(1'b1, 4'b0110, 32'd9, 32'd9, 1'b1, 4'b0001, 32'hF0, 32'h0F, 1'b1, 1'b0);
      chk("rr_id", W'(rsp_id), W'(k % 2));
      chk("rr_data", rsp_data, (k % 2 == 0) ? 32'd0 : 32'hFF);
      chk("rr_zero", W'(rsp_zero), W'(k % 2 == 0));
    end

    // Illegal op code from requester 1
    step(1'b0, 4'd0, '0, '0, 1'b1, 4'b1111, 32'h1234, 32'h5678, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("err_valid", W'(rsp_valid), 32'd1);
    chk("err_flag", W'(rsp_err), 32'd1);
    chk("err_data", rsp_data, '0);
    chk("err_id", W'(rsp_id), 32'd1);

    // Backpressure for five RESP cycles with both requesters waiting
    step(1'b1, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b0);
    idle(1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 4'd2, 32'd2, 32'd2, 1'b0, 1'b0);
      chk("bp_valid", W'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'h0F000F00);
      chk("bp_ready", W'({req0_ready, req1_ready}), '0);
    end
    idle(1'b1);
    step(1'b1, 4'd3, 32'd3, 32'd5, 1'b0, 4'd0, '0, '0, 1'b1, 1'b0);
    chk("bp_release_ready0", W'(req0_ready), 32'd1);

    // Reset during EXEC drops the op and restores the tie preference to requester 0
    step(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 4'd2, 32'd10, 32'd20, 1'b1, 4'd6, 32'd10, 32'd20, 1'b1, 1'b0);
    chk("rexec_valid", W'(rsp_valid), '0);
    chk("rexec_ready0", W'(req0_ready), 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("rexec_data", rsp_data, 32'd30);

    // Random traffic with free operand changes, random backpressure and occasional reset
    for (int k = 0; k < 400; k++) begin
      r_op0 = 4'($urandom_range(0, 15));
      r_op1 = 4'($urandom_range(0, 15));
      r_a0  = $urandom;
      r_a1  = $urandom;
      r_b0  = ($urandom_range(0, 3) == 0) ? r_a0 : $urandom;
      r_b1  = ($urandom_range(0, 3) == 0) ? r_a1 : $urandom;
      step(1'($urandom_range(0, 1)), r_op0, r_a0, r_b0,
           1'($urandom_range(0, 1)), r_op1, r_a1, r_b1,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
